// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending FSM (master) and the change dispenser (slave).
interface change_dispenser_if;
    logic       i_soda;
    logic [2:0] i_change;
    logic       i_vend_done;
    logic       i_coin_ack;
    logic       i_refill;
    logic       o_busy;
    logic       o_vend;
    logic       o_nickle_out;
    logic       o_dime_out;
    logic       o_done;
    logic       o_err;
    logic [3:0] o_nickle_stock;
    logic [3:0] o_dime_stock;

    modport master (
        output i_soda, i_change, i_vend_done, i_coin_ack, i_refill,
        input  o_busy, o_vend, o_nickle_out, o_dime_out, o_done, o_err,
               o_nickle_stock, o_dime_stock
    );

    modport slave (
        input  i_soda, i_change, i_vend_done, i_coin_ack, i_refill,
        output o_busy, o_vend, o_nickle_out, o_dime_out, o_done, o_err,
               o_nickle_stock, o_dime_stock
    );
endinterface

// File: rtl/change_dispenser.sv
// Releases the soda, then pays change coin by coin from nickel/dime hoppers,
// preferring dimes and falling back to nickels when dimes run out.
module change_dispenser #(
    parameter int NICKLE_INIT = 8,
    parameter int DIME_INIT   = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VEND, PICK, COIN_REQ, DONE, ERR} state_t;

    localparam logic [3:0] N_INIT   = 4'(NICKLE_INIT);
    localparam logic [3:0] D_INIT   = 4'(DIME_INIT);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [2:0] rem;    // remaining change in nickel units; the one-hot code maps straight across
    logic [7:0] timer;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            rem                <= 3'd0;
            timer              <= 8'd0;
            bus.o_busy         <= 1'b0;
            bus.o_vend         <= 1'b0;
            bus.o_nickle_out   <= 1'b0;
            bus.o_dime_out     <= 1'b0;
            bus.o_done         <= 1'b0;
            bus.o_err          <= 1'b0;
            bus.o_nickle_stock <= N_INIT;
            bus.o_dime_stock   <= D_INIT;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_soda) begin
                        bus.o_busy <= 1'b1;
                        if ($onehot0(bus.i_change)) begin
                            rem        <= bus.i_change;
                            timer      <= 8'd0;
                            bus.o_vend <= 1'b1;
                            state      <= VEND;
                        end else begin
                            bus.o_err <= 1'b1;
                            state     <= ERR;
                        end
                    end else if (bus.i_refill) begin
                        bus.o_nickle_stock <= N_INIT;
                        bus.o_dime_stock   <= D_INIT;
                    end
                end
                VEND: begin
                    if (bus.i_vend_done) begin
                        bus.o_vend <= 1'b0;
                        state      <= PICK;
                    end else if (timer == TMO_LAST) begin
                        bus.o_vend <= 1'b0;
                        bus.o_err  <= 1'b1;
                        state      <= ERR;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                PICK: begin
                    timer <= 8'd0;
                    if (rem == 3'd0) begin
                        bus.o_done <= 1'b1;
                        state      <= DONE;
                    end else if (rem >= 3'd2 && bus.o_dime_stock != 4'd0) begin
                        bus.o_dime_out <= 1'b1;
                        state          <= COIN_REQ;
                    end else if (bus.o_nickle_stock != 4'd0) begin
                        bus.o_nickle_out <= 1'b1;
                        state            <= COIN_REQ;
                    end else begin
                        bus.o_err <= 1'b1;
                        state     <= ERR;
                    end
                end
                COIN_REQ: begin
                    if (bus.i_coin_ack) begin
                        if (bus.o_dime_out) begin
                            bus.o_dime_stock <= bus.o_dime_stock - 4'd1;
                            rem              <= rem - 3'd2;
                        end else begin
                            bus.o_nickle_stock <= bus.o_nickle_stock - 4'd1;
                            rem                <= rem - 3'd1;
                        end
                        bus.o_dime_out   <= 1'b0;
                        bus.o_nickle_out <= 1'b0;
                        state            <= PICK;
                    end else if (timer == TMO_LAST) begin
                        bus.o_dime_out   <= 1'b0;
                        bus.o_nickle_out <= 1'b0;
                        bus.o_err        <= 1'b1;
                        state            <= ERR;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            // A vend request while busy is dropped but remembered as a fault.
            if (state != IDLE && bus.i_soda)
                bus.o_err <= 1'b1;
        end
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Output-side companion to the vending FSM: it consumes the FSM's soda/change result and physically delivers it. On each vend request it drives the soda release actuator, then pays the change one coin at a time from nickel and dime hoppers using a request/acknowledge handshake. It tracks hopper stock, substitutes nickels when dimes run out, and flags faults.

Parameters:
NICKLE_INIT, 8, nickel stock loaded at reset/refill (0..15)
DIME_INIT, 8, dime stock loaded at reset/refill (0..15)
ACK_TIMEOUT, 15, max cycles to wait for i_vend_done / i_coin_ack before fault (1..255)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_soda  in  1  1-cycle vend request pulse from vending FSM
i_change  in  3  change code sampled with i_soda: 000=0c, 001=5c, 010=10c, 100=20c
i_vend_done  in  1  soda actuator finished (level, sampled in VEND)
i_coin_ack  in  1  hopper dispensed one coin (sampled in COIN_REQ)
i_refill  in  1  pulse: reload both stocks to INIT values (honoured in IDLE only)
o_busy  out  1  high in every state except IDLE
o_vend  out  1  soda release request, high throughout VEND
o_nickle_out  out  1  nickel hopper request, level until ack
o_dime_out  out  1  dime hopper request, level until ack
o_done  out  1  1-cycle pulse: transaction complete
o_err  out  1  sticky fault flag, cleared only by reset
o_nickle_stock  out  4  current nickel count
o_dime_stock  out  4  current dime count

Behaviour:
- Reset (i_rst_n=0 at a rising edge): state IDLE; all 1-bit outputs 0; stocks = NICKLE_INIT/DIME_INIT; remaining-amount and timer = 0. Reset mid-transaction aborts immediately, no completion pulse.
- Amount held in nickel units, rem[2:0]: 000->0, 001->1, 010->2, 100->4.
- States: IDLE, VEND, PICK, COIN_REQ, DONE, ERR.
- IDLE: i_soda=1 with valid code -> latch rem, VEND next cycle (o_vend=1 one cycle after i_soda). Invalid code (two or more bits set) -> ERR. i_refill=1 and i_soda=0 -> reload stocks; if both are high, i_soda wins and the refill is dropped.
- VEND: o_vend=1; timer counts from 0 each cycle. i_vend_done=1 -> PICK. If ACK_TIMEOUT cycles pass without done -> ERR.
- PICK (1 cycle, all request outputs 0):
  - rem=0 -> DONE.
  - rem>=2 and dime stock>0 -> COIN_REQ (dime).
  - rem>=1 and nickel stock>0 -> COIN_REQ (nickel).
  - Otherwise -> ERR (short of coins).
- COIN_REQ: exactly one of o_dime_out/o_nickle_out high; timer reset on entry. On i_coin_ack=1: decrement that stock by 1, rem by 2 (dime) or 1 (nickel), request drops next cycle, -> PICK. ACK_TIMEOUT cycles without ack -> ERR, no decrement.
- Coin-order examples: 20c with full stock = dime, dime. 20c with 1 dime = dime, nickel, nickel. 10c with 0 dimes = nickel, nickel.
- DONE: o_done=1 for one cycle -> IDLE.
- ERR: o_err=1; all request outputs 0; -> IDLE next cycle. o_err stays 1 until reset; later transactions still run.
- i_soda=1 while o_busy=1: request dropped, o_err set, current transaction continues unaffected.
- i_refill outside IDLE: ignored.
- Stock never underflows. Ack only decrements when the state is COIN_REQ.
- o_nickle_out and o_dime_out are never both high. o_vend is never high together with a coin request.

Test Plan:
- Reset, i_soda with i_change=000, i_vend_done 3 cycles later -> o_vend high 3 cycles, o_done one pulse, no coin requests, stocks stay 8/8.
- i_change=100, ack each coin 2 cycles after request -> two o_dime_out requests, no nickel request, dime stock 6, nickel stock 8, o_done pulse.
- Four 100 transactions (dimes reach 0), then i_change=010 -> two o_nickle_out requests, nickel stock 6, o_done, o_err=0. Then i_refill in IDLE -> stocks 8/8.
- i_change=100 with dime stock 1 -> dime, nickel, nickel. Final stocks: dime 0, nickel 6.
- Withhold i_coin_ack for 15 cycles -> o_err=1 on the cycle after timeout, o_dime_out drops, stock unchanged, o_busy=0 the following cycle.
- Fault cases:
  - i_change=011 -> o_err=1, o_vend never asserted.
  - i_soda during VEND -> o_err=1, original transaction still completes.
  - Reset asserted during COIN_REQ -> all outputs 0 after that edge, stocks back to 8/8.
